// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: generic bank of NUM_STAGES pipeline registers with
// per-stage hold, per-stage flush, valid/ready backpressure at the tail and
// saturating performance counters for stalls, bubbles, flushes and retirements.
module pipe_stage_ctrl #(
    parameter int                NUM_STAGES = 4,
    parameter int                DATA_W     = 32,
    parameter int                CNT_W      = 16,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    input  logic [DATA_W-1:0]            in_data_i,
    output logic                         in_ready_o,
    input  logic [NUM_STAGES-1:0]        hold_i,
    input  logic [NUM_STAGES-1:0]        flush_i,
    output logic [NUM_STAGES-1:0]        stage_valid_o,
    output logic [NUM_STAGES*DATA_W-1:0] stage_data_o,
    output logic                         out_valid_o,
    output logic [DATA_W-1:0]            out_data_o,
    input  logic                         out_ready_i,
    input  logic                         clr_cnt_i,
    output logic [CNT_W-1:0]             stall_cnt_o,
    output logic [CNT_W-1:0]             bubble_cnt_o,
    output logic [CNT_W-1:0]             flush_cnt_o,
    output logic [CNT_W-1:0]             retire_cnt_o
);

    // Wide enough to hold a saturated counter plus the largest per-cycle increment.
    localparam int SUM_W = CNT_W + $clog2(NUM_STAGES + 2) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [NUM_STAGES-1:0] valid_q;
    logic [DATA_W-1:0]     data_q  [NUM_STAGES];
    logic [DATA_W-1:0]     srcData [NUM_STAGES];
    logic [NUM_STAGES:0]   take;
    logic [NUM_STAGES-1:0] fwdValid;
    logic                  outFire;

    logic [CNT_W-1:0] stallCnt_q,  stallCnt_d;
    logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
    logic [CNT_W-1:0] flushCnt_q,  flushCnt_d;
    logic [CNT_W-1:0] retireCnt_q, retireCnt_d;
    logic [SUM_W-1:0] bubbleInc;
    logic [SUM_W-1:0] flushInc;

    // Adds a per-cycle increment and clamps at the counter's all-ones value.
    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] cnt,
                                                 input logic [SUM_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = {{(SUM_W-CNT_W){1'b0}}, cnt} + inc;
        if (sum > CNT_MAX) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    // Ripple the "stage k loads this cycle" term from the sink back to the input.
    always_comb begin
        take             = '0;
        take[NUM_STAGES] = out_ready_i;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            take[k] = !hold_i[k] & (!valid_q[k] | flush_i[k] | take[k+1]);
        end
    end

    // Source valid/data for each stage; a held or flushed upstream stage forwards a bubble.
    always_comb begin
        fwdValid    = '0;
        fwdValid[0] = in_valid_i;
        srcData[0]  = in_data_i;
        for (int k = 1; k < NUM_STAGES; k++) begin
            fwdValid[k] = valid_q[k-1] & !hold_i[k-1] & !flush_i[k-1];
            srcData[k]  = data_q[k-1];
        end
    end

    // Stage registers: flush kills, take loads payload or bubble, otherwise keep.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= BUBBLE_VAL;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (flush_i[k]) begin
                    valid_q[k] <= 1'b0;
                    data_q[k]  <= BUBBLE_VAL;
                end else if (take[k]) begin
                    valid_q[k] <= fwdValid[k];
                    data_q[k]  <= fwdValid[k] ? srcData[k] : BUBBLE_VAL;
                end
            end
        end
    end

    // Per-cycle counter increments derived from this cycle's handshakes.
    always_comb begin
        bubbleInc = '0;
        flushInc  = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (take[k+1] & hold_i[k] & valid_q[k] & !flush_i[k]) begin
                bubbleInc = bubbleInc + SUM_W'(1);
            end
            if (flush_i[k] & valid_q[k]) begin
                flushInc = flushInc + SUM_W'(1);
            end
        end
        if (flush_i[0] & in_valid_i & take[0]) begin
            flushInc = flushInc + SUM_W'(1);
        end
    end

    // Next counter values: clear wins, otherwise saturating increment.
    always_comb begin
        if (clr_cnt_i) begin
            stallCnt_d  = '0;
            bubbleCnt_d = '0;
            flushCnt_d  = '0;
            retireCnt_d = '0;
        end else begin
            stallCnt_d  = satAdd(stallCnt_q, SUM_W'(|hold_i));
            bubbleCnt_d = satAdd(bubbleCnt_q, bubbleInc);
            flushCnt_d  = satAdd(flushCnt_q, flushInc);
            retireCnt_d = satAdd(retireCnt_q, SUM_W'(outFire));
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stallCnt_q  <= '0;
            bubbleCnt_q <= '0;
            flushCnt_q  <= '0;
            retireCnt_q <= '0;
        end else begin
            stallCnt_q  <= stallCnt_d;
            bubbleCnt_q <= bubbleCnt_d;
            flushCnt_q  <= flushCnt_d;
            retireCnt_q <= retireCnt_d;
        end
    end

    // Flatten the stage payloads onto the observation bus.
    always_comb begin
        stage_data_o = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_data_o[k*DATA_W +: DATA_W] = data_q[k];
        end
    end

    assign outFire       = out_valid_o & out_ready_i;
    assign in_ready_o    = take[0];
    assign stage_valid_o = valid_q;
    assign out_valid_o   = valid_q[NUM_STAGES-1] & !flush_i[NUM_STAGES-1];
    assign out_data_o    = data_q[NUM_STAGES-1];
    assign stall_cnt_o   = stallCnt_q;
    assign bubble_cnt_o  = bubbleCnt_q;
    assign flush_cnt_o   = flushCnt_q;
    assign retire_cnt_o  = retireCnt_q;

endmodule
